ex_muldiv_ctrl: RTL and testbench
=================================

// Module: ex_muldiv_ctrl
// PURPOSE
//  Sequencer for the EX-stage multiply/divide resource and owner of HI/LO.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs multi-cycle mul/div.
//  Stalls the pipeline while an operation is in flight and writes HI/LO on completion.
//  hi_o/lo_o are the architectural HI/LO registers read by MFHI/MFLO.
// PARAMETERS
//  DATA_W      32  operand/HI/LO width
//  MUL_CYCLES  3   multiplier latency in cycles (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  op_valid   in   1       EX holds a valid HI/LO-class instruction
//  op         in   3       `MD_MULT/MULTU/DIV/DIVU/MTHI/MTLO (from muldiv_defs.vh)
//  rs_data    in   DATA_W  operand A (dividend/multiplicand/MTxx source)
//  rt_data    in   DATA_W  operand B (divisor/multiplier)
//  flush      in   1       exception/redirect; abort the in-flight op
//  stall_o    out  1       hold IF..EX; combinational
//  done_o     out  1       1-cycle pulse; HI/LO were just updated by mul/div
//  hi_o       out  DATA_W  HI register
//  lo_o       out  DATA_W  LO register
// BEHAVIOUR
//  Reset: state=IDLE, hi_o=lo_o=0, done_o=0, counter=0. stall_o=0 while no op is presented.
//  States: IDLE, MUL, DIV, DIV_FIX, DONE.
//  IDLE, op_valid && !flush:
//   MTHI/MTLO: write hi_o/lo_o at the edge, no stall, stay IDLE.
//   MULT/MULTU: latch operands -> MUL with cnt=MUL_CYCLES-1.
//   DIV/DIVU, rt!=0: latch |A|,|B| (signed) or A,B -> DIV with cnt=DATA_W-1.
//   DIV/DIVU, rt==0: -> DONE; hi=rs_data, lo={DATA_W{1'b1}}.
//  MUL: decrement cnt. At cnt==0, write {hi,lo}=product (signed or unsigned, 2*DATA_W) -> DONE.
//  DIV: one restoring step per cycle, MSB first. At cnt==0 -> DIV_FIX.
//  DIV_FIX: signed only: negate q if signs differ; rem takes dividend's sign.
//   Write lo=q, hi=rem -> DONE. 0x80000000/-1 gives lo=0x80000000, hi=0.
//  DONE: done_o=1, stall_o=0, so the held instruction advances. op_valid is ignored. -> IDLE.
//  stall_o = (state in MUL,DIV,DIV_FIX)
//            || (state==IDLE && op_valid && !flush && op is MULT/MULTU/DIV/DIVU).
//  Stall cycles: mul = 1+MUL_CYCLES; div = DATA_W+2 (34); div-by-zero = 1.
//  flush in any state: -> IDLE at the edge. HI/LO unchanged, done_o=0, stall_o=0 that cycle.
//   A flush in the same cycle as completion wins: no write.
//  An op presented while state!=IDLE is ignored; the pipeline is stalled, so none is legal.
//  Invalid op codes: no-op, no stall.
//  Async reset mid-operation: immediate return to reset values; the partial result is discarded.
// STRUCTURE
//  muldiv_defs.vh (shared, `ifndef-guarded):
//   MD_* op encodings, 3'd0..3'd5; state encodings.
//  Sub-module muldiv_div_step: combinational restoring step.
//   In:  rem[DATA_W], quo[DATA_W], divisor[DATA_W].
//   Out: next rem/quo (shift, trial subtract, select).
//  Multiplier: behavioural '*' on latched operands. Result taken at the end of the MUL count.
// TESTING
//  MULT rs=-3, rt=7 -> stall 4 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; done_o 1 cycle.
//  MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE.
//  DIV rs=-7, rt=2 -> stall 34 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//  DIVU rs=100, rt=0 -> stall 1 cycle; hi=100, lo=0xFFFFFFFF.
//  DIVU 100/7 with flush at DIV cycle 10 -> stall drops that cycle; HI/LO keep prior values.
//   A following MTLO 0x1234 -> lo=0x1234, no stall.
//  Assert rst_n low during a MUL -> outputs 0 immediately.
//   DIV 0x80000000/-1 -> lo=0x80000000, hi=0.

Source files
------------

// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer:
// HI/LO-class op codes and FSM state encodings.
package ex_muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL     = 3'd1,
        ST_DIV     = 3'd2,
        ST_DIV_FIX = 3'd3,
        ST_DONE    = 3'd4
    } md_state_e;

    // Ops that occupy the mul/div resource for more than one cycle.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// trial-subtract the divisor, keep the difference when it does not borrow.
module ex_muldiv_ctrl_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // One extra bit: a remainder near 2^DATA_W-1 overflows DATA_W when shifted.
    assign shifted = {rem_i, quo_i[DATA_W-1]};
    assign trial   = shifted - {1'b0, divisor_i};

    always_comb begin
        rem_o = shifted[DATA_W-1:0];
        quo_o = {quo_i[DATA_W-2:0], 1'b0};
        if (!trial[DATA_W]) begin
            rem_o = trial[DATA_W-1:0];
            quo_o = {quo_i[DATA_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage multiply/divide sequencer and owner of the architectural HI/LO
// registers; stalls the pipeline while a multi-cycle op is in flight.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | accept MTHI/MTLO (single cycle) or launch MULT/DIV
// ST_MUL     | multiplier latency count, product written at count 0
// ST_DIV     | one restoring step per cycle, MSB first
// ST_DIV_FIX | sign correction of quotient/remainder, HI/LO written
// ST_DONE    | done pulse, stall released so the held op advances
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_MAX = (DATA_W > MUL_CYCLES) ? DATA_W : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    md_state_e           state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                sgn_q;
    logic                q_neg_q;
    logic                r_neg_q;
    logic                done_q;

    logic [DATA_W-1:0]   rem_d;
    logic [DATA_W-1:0]   quo_d;
    logic [2*DATA_W-1:0] prod;
    logic                a_ext;
    logic                b_ext;
    logic                div_signed;
    logic                rs_neg;
    logic                rt_neg;
    logic [DATA_W-1:0]   rs_mag;
    logic [DATA_W-1:0]   rt_mag;

    // Sign-extend to full width so one unsigned multiply serves both MULT and MULTU.
    assign a_ext = sgn_q & a_q[DATA_W-1];
    assign b_ext = sgn_q & b_q[DATA_W-1];
    assign prod  = {{DATA_W{a_ext}}, a_q} * {{DATA_W{b_ext}}, b_q};

    assign div_signed = (op == MD_DIV);
    assign rs_neg     = div_signed & rs_data[DATA_W-1];
    assign rt_neg     = div_signed & rt_data[DATA_W-1];
    assign rs_mag     = rs_neg ? -rs_data : rs_data;
    assign rt_mag     = rt_neg ? -rt_data : rt_data;

    ex_muldiv_ctrl_div_step #(
        .DATA_W(DATA_W)
    ) u_div_step (
        .rem_i    (rem_q),
        .quo_i    (a_q),
        .divisor_i(b_q),
        .rem_o    (rem_d),
        .quo_o    (quo_d)
    );

    assign stall_o = !flush &&
                     ((state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_DIV_FIX) ||
                      ((state_q == ST_IDLE) && op_valid && is_long_op(op)));
    assign done_o  = done_q && !flush;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (op_valid) begin
                            case (op)
                                MD_MTHI: hi_q <= rs_data;
                                MD_MTLO: lo_q <= rs_data;
                                MD_MULT, MD_MULTU: begin
                                    a_q     <= rs_data;
                                    b_q     <= rt_data;
                                    sgn_q   <= (op == MD_MULT);
                                    cnt_q   <= CNT_W'(MUL_CYCLES - 1);
                                    state_q <= ST_MUL;
                                end
                                MD_DIV, MD_DIVU: begin
                                    if (rt_data == '0) begin
                                        hi_q    <= rs_data;
                                        lo_q    <= '1;
                                        done_q  <= 1'b1;
                                        state_q <= ST_DONE;
                                    end else begin
                                        a_q     <= rs_mag;
                                        b_q     <= rt_mag;
                                        rem_q   <= '0;
                                        q_neg_q <= rs_neg ^ rt_neg;
                                        r_neg_q <= rs_neg;
                                        cnt_q   <= CNT_W'(DATA_W - 1);
                                        state_q <= ST_DIV;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        if (cnt_q == '0) begin
                            {hi_q, lo_q} <= prod;
                            done_q       <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_DIV: begin
                        rem_q <= rem_d;
                        a_q   <= quo_d;
                        if (cnt_q == '0) begin
                            state_q <= ST_DIV_FIX;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_DIV_FIX: begin
                        // Magnitude quotient of MIN/-1 is 2^(W-1); negating it wraps back to MIN.
                        lo_q    <= q_neg_q ? -a_q : a_q;
                        hi_q    <= r_neg_q ? -rem_q : rem_q;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: directed vectors plus random ops, compared against
// an arithmetic model of HI/LO results, stall length and done pulse.
module tb_ex_muldiv_ctrl;

    localparam int DATA_W     = 32;
    localparam int MUL_CYCLES = 3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op       = 3'd0;
    logic [31:0] rs_data  = '0;
    logic [31:0] rt_data  = '0;
    logic        flush    = 1'b0;
    logic        stall_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    ex_muldiv_ctrl #(
        .DATA_W    (DATA_W),
        .MUL_CYCLES(MUL_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .op_valid(op_valid),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .flush   (flush),
        .stall_o (stall_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural effect of one op: stall length, done pulses, new HI/LO.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int st, output int dn, output logic [31:0] nh, output logic [31:0] nl);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        st = 0;
        dn = 0;
        nh = m_hi;
        nl = m_lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            OP_MULT, OP_MULTU: begin
                if (o == OP_MULT) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                else              p = ua * ub;
                st = 1 + MUL_CYCLES;
                dn = 1;
                nh = p[63:32];
                nl = p[31:0];
            end
            OP_DIV, OP_DIVU: begin
                dn = 1;
                if (b == 32'h0) begin
                    st = 1;
                    nh = a;
                    nl = 32'hFFFF_FFFF;
                end else begin
                    st = DATA_W + 2;
                    if (o == OP_DIV) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'(ua / ub);
                        r = longint'(ua % ub);
                    end
                    nh = r[31:0];
                    nl = q[31:0];
                end
            end
            OP_MTHI: nh = a;
            OP_MTLO: nl = a;
            default: ;
        endcase
    endtask

    // Present an op at posedge+1 and hold it while stalled; optional flush at cycle flush_at.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input string tag);
        int          exp_st, exp_dn, st_cnt, dn_cnt;
        logic [31:0] nh, nl;
        logic        st, timeout;
        model(o, a, b, exp_st, exp_dn, nh, nl);
        if (flush_at >= 0 && (flush_at == 0 || flush_at < exp_st)) begin
            exp_st = flush_at;
            exp_dn = 0;
            nh     = m_hi;
            nl     = m_lo;
        end
        st_cnt   = 0;
        dn_cnt   = 0;
        timeout  = 1'b1;
        op_valid = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        for (int i = 0; i < 100; i++) begin
            if (i == flush_at) flush = 1'b1;
            @(negedge clk);
            st = stall_o;
            if (st) st_cnt++;
            if (done_o) dn_cnt++;
            @(posedge clk);
            #1;
            flush = 1'b0;
            if (!st) begin
                timeout = 1'b0;
                break;
            end
        end
        op_valid = 1'b0;
        check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
        check_eq({tag, "_stall_cycles"}, st_cnt, exp_st);
        check_eq({tag, "_done_pulses"}, dn_cnt, exp_dn);
        check_eq({tag, "_hi"}, hi_o, nh);
        check_eq({tag, "_lo"}, lo_o, nl);
        m_hi = nh;
        m_lo = nl;
        @(negedge clk);
        check_eq({tag, "_idle_done"}, 32'(done_o), 32'd0);
        check_eq({tag, "_idle_stall"}, 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b, nh, nl;
        int          nst, ndn, fa, sel;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hi", hi_o, 32'h0);
        check_eq("rst_lo", lo_o, 32'h0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, -1, "mult_neg");
        check_eq("mult_neg_hi_lit", hi_o, 32'hFFFF_FFFF);
        check_eq("mult_neg_lo_lit", lo_o, 32'hFFFF_FFEB);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, -1, "multu");
        check_eq("multu_hi_lit", hi_o, 32'h0000_0001);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, "div_neg");
        check_eq("div_neg_lo_lit", lo_o, 32'hFFFF_FFFD);
        check_eq("div_neg_hi_lit", hi_o, 32'hFFFF_FFFF);
        run_op(OP_DIVU, 32'd100, 32'd0, -1, "divu_zero");
        run_op(OP_DIVU, 32'd100, 32'd7, 10, "divu_flush");
        run_op(OP_MTLO, 32'h0000_1234, 32'h0, -1, "mtlo");
        run_op(OP_MTHI, 32'h0000_CAFE, 32'h0, -1, "mthi");
        run_op(3'd6, 32'h1111_1111, 32'h2, -1, "invalid");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        check_eq("div_ovf_lo_lit", lo_o, 32'h8000_0000);
        check_eq("div_ovf_hi_lit", hi_o, 32'h0);
        run_op(OP_MTHI, 32'h0BAD_F00D, 32'h0, -1, "mthi2");

        // Async reset in the middle of a multiply.
        op_valid = 1'b1;
        op       = OP_MULT;
        rs_data  = 32'd5;
        rt_data  = 32'd9;
        repeat (2) @(posedge clk);
        #3;
        op_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_eq("arst_hi", hi_o, 32'h0);
        check_eq("arst_lo", lo_o, 32'h0);
        check_eq("arst_stall", 32'(stall_o), 32'd0);
        check_eq("arst_done", 32'(done_o), 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 60; k++) begin
            o   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                b = 32'h0;
            end else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                b = 32'($urandom_range(1, 15));
            end
            model(o, a, b, nst, ndn, nh, nl);
            fa = -1;
            if ($urandom_range(0, 5) == 0) fa = (nst > 0) ? int'($urandom_range(0, nst - 1)) : 0;
            run_op(o, a, b, fa, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
